muldiv_iter: RTL
================

// Module: muldiv_iter
// PURPOSE
//   Iterative multi-cycle multiply/divide unit that produces HI/LO results for MULT/MULTU/DIV/DIVU.
//   Replaces the single-cycle combinational multiply path in the execute-stage ALU.
//   Sits beside the ALU in EX: accepts one operation per start pulse and stalls the pipeline via busy_o.
//   Supports cancellation on exception flush; the HI/LO register file writes from hi_o/lo_o on done_o.
// PARAMETERS
//   WIDTH      32   operand width; product/quotient/remainder are WIDTH bits per half
//   CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   resetn     in   1      synchronous reset, active low
//   start_i    in   1      request new operation (sampled only when busy_o=0)
//   op_i       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a_i    in   WIDTH  multiplicand / dividend
//   src_b_i    in   WIDTH  multiplier / divisor
//   cancel_i   in   1      exception flush: abort in-flight operation
//   busy_o     out  1      operation in progress (stall EX)
//   done_o     out  1      one-cycle pulse: hi_o/lo_o hold a new result
//   hi_o       out  WIDTH  MULT*: product[2W-1:W]; DIV*: remainder
//   lo_o       out  WIDTH  MULT*: product[W-1:0];  DIV*: quotient
// BEHAVIOUR
//   Reset (resetn=0 at clk edge): state=IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0.
//   FSM states IDLE, BUSY, DONE:
//   - IDLE: start_i=1 & cancel_i=0 -> latch op, operand magnitudes, sign flags; counter=0; go BUSY.
//   - BUSY: one radix-2 step per cycle (shift-add multiply / restoring divide on magnitudes).
//     After exactly WIDTH steps, write sign-corrected result to hi_o/lo_o and go DONE.
//   - DONE: done_o=1 for exactly this cycle. Next state is BUSY if start_i=1, else IDLE.
//   busy_o=1 only in BUSY. start_i in BUSY is ignored; no queueing.
//   Latency: start sampled at edge 0 -> BUSY for cycles 1..WIDTH -> done_o=1 in cycle WIDTH+1.
//   Back-to-back: start in DONE cycle gives next done_o exactly WIDTH+1 cycles later.
//   Signed ops (MULT, DIV): operate on |a|, |b| (two's-complement negate when MSB set).
//   - MULT: negate the 2W-bit product if sign(a)^sign(b).
//   - DIV: negate quotient if sign(a)^sign(b); remainder takes sign of dividend.
//   Unsigned ops (MULTU, DIVU): operands used as-is, no correction.
//   Divide by zero (src_b_i=0), any signedness: full latency; hi_o=src_a_i, lo_o={WIDTH{1'b1}}.
//   Signed overflow -2^(W-1)/-1: lo_o=2^(W-1) (wraps), hi_o=0; no flag.
//   cancel_i=1 in BUSY or DONE -> IDLE next cycle; done_o=0 next cycle; hi_o/lo_o unchanged.
//   cancel_i=1 with start_i=1 in IDLE or DONE: cancel wins, operation not accepted.
//   Latched operands are not affected by src_*_i changes after acceptance.
//   hi_o/lo_o hold the last completed result until the next completion or reset.
//   resetn=0 mid-operation: immediate return to reset values; no done_o.
// TESTING
//   MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done_o in cycle 33, hi=0xFFFFFFFE lo=0x00000001.
//   MULT a=0xFFFFFFFE(-2) b=0x00000003 -> hi=0xFFFFFFFF lo=0xFFFFFFFA; busy_o=1 for 32 cycles.
//   DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1);
//     DIVU a=7 b=0 -> hi=7 lo=0xFFFFFFFF.
//   DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0;
//     start re-asserted in DONE -> next done exactly 33 cycles later.
//   Start DIVU 100/7, cancel_i at cycle 10 -> idle in cycle 11, no done_o, hi/lo keep prior values;
//     start_i while busy ignored.
//   resetn=0 at cycle 5 of a MULT -> busy_o=0, hi_o=lo_o=0;
//     new start after reset completes normally in 33 cycles.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide unit producing HI/LO results
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic is_div, neg_q, neg_r, accept, last, ge, sa, sb;
    logic [WIDTH-1:0] acc, lo_reg, opnd, acc_nxt, lo_nxt, mag_a, mag_b, res_hi, res_lo;
    logic [WIDTH:0] sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0] cnt;
    assign busy_o = state == BUSY;
    assign done_o = state == DONE;
    assign accept = start_i & ~cancel_i & (state != BUSY);
    assign last = cnt == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk)
        if (!resetn) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = cancel_i ? IDLE : state == BUSY ? (last ? DONE : BUSY) : (start_i ? BUSY : IDLE);
    end
    // acc/lo_reg form the 2W-bit product (multiply) or remainder/quotient pair (divide)
    always_comb begin
        sa = op_i[0] & src_a_i[WIDTH-1];
        sb = op_i[0] & src_b_i[WIDTH-1];
        mag_a = sa ? -src_a_i : src_a_i;
        mag_b = sb ? -src_b_i : src_b_i;
        sum = {1'b0, acc} + (lo_reg[0] ? {1'b0, opnd} : '0);
        shifted = {acc, lo_reg[WIDTH-1]};
        diff = shifted - {1'b0, opnd};
        ge = shifted >= {1'b0, opnd};
        acc_nxt = is_div ? (ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        lo_nxt = is_div ? {lo_reg[WIDTH-2:0], ge} : {sum[0], lo_reg[WIDTH-1:1]};
        prod = neg_q ? -{acc_nxt, lo_nxt} : {acc_nxt, lo_nxt};
        res_hi = is_div ? (neg_r ? -acc_nxt : acc_nxt) : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (neg_q ? -lo_nxt : lo_nxt) : prod[WIDTH-1:0];
    end
    // Divide by zero yields all-ones quotient and |a| remainder; neg_q is suppressed so lo stays all ones
    always_ff @(posedge clk) begin
        if (!resetn) begin
            {is_div, neg_q, neg_r} <= '0;
            {acc, lo_reg, opnd, hi_o, lo_o} <= '0;
            cnt <= '0;
        end else if (accept) begin
            is_div <= op_i[1];
            neg_q <= (sa ^ sb) & (~op_i[1] | (|src_b_i));
            neg_r <= sa;
            acc <= '0;
            lo_reg <= op_i[1] ? mag_a : mag_b;
            opnd <= op_i[1] ? mag_b : mag_a;
            cnt <= '0;
        end else if (busy_o && !cancel_i) begin
            acc <= acc_nxt;
            lo_reg <= lo_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                hi_o <= res_hi;
                lo_o <= res_lo;
            end
        end
    end
endmodule
